// File: rtl/mux_scan_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mux_scan_sequencer
//  Brief    : Four-channel time-division scan controller driving the select
//             lines of a downstream 4:1 mux. Walks the unmasked channels in
//             ascending order, settles DWELL cycles on each, captures the mux
//             output into a frame buffer and offers the finished 4-bit frame
//             through a valid/ready handshake.
//  Options  : MUX_SCAN_CONT_EN - when defined, a completed handshake restarts
//             the scan immediately with a freshly latched mask (continuous
//             mode). When undefined, every frame needs its own start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_scan_sequencer #(
   parameter int DWELL = 4,   // settle cycles per channel, 1..255
   parameter int CW    = 8    // dwell counter width, 2^CW > DWELL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] mask,
   input  logic       mux_out,
   output logic       s0,
   output logic       s1,
   output logic [3:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DWELL   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [CW-1:0] c_cnt_load = CW'(DWELL - 1);

   state_t        state_q, state_d;
   logic [1:0]    ch_q, ch_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    mask_q, mask_d;
   logic [3:0]    fbuf_q, fbuf_d;
   logic [3:0]    frame_q, frame_d;
   logic          valid_q, valid_d;

   logic [2:0]    w_first;   // {found, index} of lowest unmasked channel in mask input
   logic [2:0]    w_next;    // {found, index} of next unmasked channel above ch_q

   // Returns {found, index} of the lowest channel >= from whose mask bit is clear.
   function automatic logic [2:0] f_find_free(input logic [3:0] m, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (!m[i] && (i >= int'(from))) begin
            r = {1'b1, 2'(i)};
         end
      end
      return r;
   endfunction

   assign w_first = f_find_free(mask, 3'd0);
   assign w_next  = f_find_free(mask_q, {1'b0, ch_q} + 3'd1);

   // Selects come straight from the channel register so they never glitch.
   assign s0          = ch_q[0];
   assign s1          = ch_q[1];
   assign frame       = frame_q;
   assign frame_valid = valid_q;
   assign busy        = (state_q != S_IDLE);

   // State and datapath registers; reset discards any partial frame at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= 2'd0;
         cnt_q   <= '0;
         mask_q  <= 4'h0;
         fbuf_q  <= 4'h0;
         frame_q <= 4'h0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         fbuf_q  <= fbuf_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic: scan sequencing, capture and frame handshake.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      fbuf_d  = fbuf_q;
      frame_d = frame_q;
      valid_d = valid_q;

      case (state_q)
         S_IDLE: begin
            ch_d = 2'd0;
            // An all-masked request has nothing to scan and is dropped.
            if (start && (mask != 4'hF)) begin
               mask_d  = mask;
               ch_d    = w_first[1:0];
               fbuf_d  = 4'h0;
               cnt_d   = c_cnt_load;
               state_d = S_DWELL;
            end
         end

         S_DWELL: begin
            if (cnt_q == '0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_CAPTURE: begin
            fbuf_d[ch_q] = mux_out;
            if (w_next[2]) begin
               ch_d    = w_next[1:0];
               cnt_d   = c_cnt_load;
               state_d = S_DWELL;
            end else begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            // First DONE cycle publishes the buffer; the frame then holds
            // until the consumer takes it.
            if (!valid_q) begin
               valid_d = 1'b1;
               frame_d = fbuf_q;
            end else if (frame_ready) begin
               valid_d = 1'b0;
`ifdef MUX_SCAN_CONT_EN
               if (mask != 4'hF) begin
                  mask_d  = mask;
                  ch_d    = w_first[1:0];
                  fbuf_d  = 4'h0;
                  cnt_d   = c_cnt_load;
                  state_d = S_DWELL;
               end else begin
                  ch_d    = 2'd0;
                  state_d = S_IDLE;
               end
`else
               ch_d    = 2'd0;
               state_d = S_IDLE;
`endif
            end
         end

         default: begin
            ch_d    = 2'd0;
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mux_scan_sequencer
//  Brief    : Self-checking bench for mux_scan_sequencer (single-shot build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan_sequencer;

   localparam int DWELL = 4;
   localparam int CW    = 8;

   localparam int M_ZERO = 0;
   localparam int M_ONE  = 1;
   localparam int M_NS0  = 2;
   localparam int M_S1   = 3;
   localparam int M_XOR  = 4;
   localparam int M_RAND = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] mask = 4'h0;
   logic       mux_out;
   logic       s0, s1;
   logic [3:0] frame;
   logic       frame_valid;
   logic       frame_ready = 1'b1;
   logic       busy;

   int         mux_mode = M_ZERO;
   logic       r_mux = 1'b0;

   int         n_cmp = 0;
   int         n_err = 0;

   typedef struct {
      logic [3:0] mask;
      int         mode;
      logic [3:0] exp_frame;
   } vec_t;

   vec_t vt[6];

   mux_scan_sequencer #(.DWELL(DWELL), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mask        (mask),
      .mux_out     (mux_out),
      .s0          (s0),
      .s1          (s1),
      .frame       (frame),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the 4:1 mux and its data inputs.
   always_comb begin
      case (mux_mode)
         M_ZERO:  mux_out = 1'b0;
         M_ONE:   mux_out = 1'b1;
         M_NS0:   mux_out = ~s0;
         M_S1:    mux_out = s1;
         M_XOR:   mux_out = s0 ^ s1;
         default: mux_out = r_mux;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 25)
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Directed scan: checks latency, select order, frame and one-cycle valid.
   task automatic run_vec(input logic [3:0] m, input int mode, input logic [3:0] ef,
                          input int hold, input bit pulses);
      logic [1:0] seen[$];
      logic [1:0] lst[$];
      int         edges;
      for (int i = 0; i < 4; i++) if (!m[i]) lst.push_back(2'(i));
      mux_mode    = mode;
      frame_ready = (hold == 0);
      @(negedge clk);
      mask  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mask  = 4'($urandom);
      edges = 0;
      while (!frame_valid && edges < 200) begin
         if (busy && (seen.size() == 0 || seen[$] != {s1, s0})) seen.push_back({s1, s0});
         start = pulses && (edges == 3);
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      chk("valid_latency", edges, lst.size() * (DWELL + 1) + 1);
      chk("sel_count", seen.size(), lst.size());
      for (int i = 0; i < lst.size(); i++)
         if (i < seen.size()) chk("sel_order", seen[i], lst[i]);
      chk("frame", frame, ef);
      for (int i = 0; i < hold; i++) begin
         mux_mode = M_RAND;
         r_mux    = ~r_mux;
         start    = pulses && (i % 2 == 0);
         @(posedge clk); #1;
         chk("hold_valid", frame_valid, 1);
         chk("hold_frame", frame, ef);
         chk("hold_busy", busy, 1);
      end
      start       = 1'b0;
      frame_ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", frame_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_sel", {s1, s0}, 0);
      @(posedge clk); #1;
      chk("idle_stays", busy, 0);
   endtask

   // Random scan against a timing model derived from per-channel DWELL+1 slots.
   task automatic run_rand();
      logic [3:0] m;
      logic [1:0] lst[$];
      logic [3:0] ef;
      int         p, t, k;
      bit         done, vexp, hs;
      do m = 4'($urandom); while (m == 4'hF);
      for (int i = 0; i < 4; i++) if (!m[i]) lst.push_back(2'(i));
      p        = lst.size() * (DWELL + 1);
      ef       = 4'h0;
      mux_mode = M_RAND;
      @(negedge clk);
      mask        = m;
      start       = 1'b1;
      frame_ready = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      t     = 0;
      done  = 0;
      while (!done && t < 300) begin
         vexp = (t >= p + 1);
         chk("r_busy", busy, 1);
         chk("r_valid", frame_valid, vexp);
         chk("r_sel", {s1, s0}, (t < p) ? lst[t / (DWELL + 1)] : lst[lst.size() - 1]);
         if (vexp) chk("r_frame", frame, ef);
         r_mux       = 1'($urandom);
         frame_ready = 1'($urandom);
         start       = 1'($urandom);
         mask        = 4'($urandom);
         if (((t + 1) % (DWELL + 1) == 0) && (t + 1 <= p)) begin
            k = (t + 1) / (DWELL + 1) - 1;
            ef[lst[k]] = r_mux;
         end
         hs = vexp && frame_ready;
         @(posedge clk); #1;
         start = 1'b0;
         t++;
         if (hs) begin
            done = 1;
            chk("r_hs_valid", frame_valid, 0);
            chk("r_hs_busy", busy, 0);
            chk("r_hs_sel", {s1, s0}, 0);
         end
      end
      if (!done) chk("r_timeout", 0, 1);
   endtask

   initial begin
      vt[0] = '{4'h0,    M_NS0,  4'b0101};
      vt[1] = '{4'b1010, M_ONE,  4'b0101};
      vt[2] = '{4'h0,    M_S1,   4'b1100};
      vt[3] = '{4'b0100, M_XOR,  4'b0010};
      vt[4] = '{4'b0111, M_ONE,  4'b1000};
      vt[5] = '{4'b1110, M_NS0,  4'b0001};

      #1 rst = 1'b1;
      #2;
      chk("rst_sel", {s1, s0}, 0);
      chk("rst_frame", frame, 0);
      chk("rst_valid", frame_valid, 0);
      chk("rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vt[i].mask, vt[i].mode, vt[i].exp_frame, 0, 0);

      // All channels masked: request must be ignored.
      @(negedge clk);
      mask  = 4'hF;
      start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         chk("maskF_busy", busy, 0);
         chk("maskF_sel", {s1, s0}, 0);
      end
      start = 1'b0;

      // Back-pressure with stray starts in DWELL and DONE.
      run_vec(4'h0, M_NS0, 4'b0101, 10, 1);

      // Asynchronous reset during channel 2 dwell.
      @(negedge clk);
      mux_mode = M_NS0;
      mask     = 4'h0;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_sel", {s1, s0}, 2);
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_sel", {s1, s0}, 0);
      chk("arst_frame", frame, 0);
      chk("arst_valid", frame_valid, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk) rst = 1'b0;
      run_vec(4'h0, M_S1, 4'b1100, 0, 0);

      for (int i = 0; i < 40; i++) run_rand();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
